// File: rtl/wallace_reduce_16x16_pipe.sv
// ---------------------------------------------------------------------------
// wallace_reduce_16x16_pipe
//
// Pipelined front end of the 16-bit signed Wallace-tree multiplier.
// Builds the Baugh-Wooley partial-product matrix of two 16-bit
// two's-complement operands. It then reduces the matrix with 3:2 counters
// to two rows. The low product byte is resolved inside this block. The
// upper 24 columns leave as two carry-save rows plus a carry-in, which
// feed the 24-bit CLA final adder (row_a->a, row_b->b, cin_out->c0).
//
// Pipeline: P1 holds the partial-product matrix, P2 holds the reduced
// result. Each stage advances when it is empty or when its successor
// advances. Latency is 2 cycles and throughput is one result per cycle.
//
// Optional build macro: WALLACE_MID_PIPE_EN
//   When defined, a register stage P1b is inserted after the first three
//   reduction levels (16 rows -> 6 rows), and latency becomes 3 cycles.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operands valid
//   in_ready   out  block accepts operands this cycle
//   a, b       in   16-bit signed multiplicand / multiplier
//   out_valid  out  result rows valid
//   out_ready  in   downstream adder stage accepts
//   low_prod   out  product bits [7:0], final
//   row_a      out  first reduced row, weight 2^8
//   row_b      out  second reduced row, weight 2^8
//   cin_out    out  carry out of the low 8-bit region, weight 2^8
// ---------------------------------------------------------------------------
module wallace_reduce_16x16_pipe #(
    parameter int WIDTH    = 16,
    parameter int LOW_BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              a,
    input  logic [WIDTH-1:0]              b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LOW_BITS-1:0]           low_prod,
    output logic [2*WIDTH-LOW_BITS-1:0]   row_a,
    output logic [2*WIDTH-LOW_BITS-1:0]   row_b,
    output logic                          cin_out
);

    localparam int PROD_W = 2 * WIDTH;

    // 3:2 counter applied bitwise across three aligned rows: sum part.
    function automatic logic [PROD_W-1:0] csa_sum(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        return x ^ y ^ z;
    endfunction

    // 3:2 counter carry part, moved up one column; carries out of the
    // top column fall off, which keeps everything modulo 2^32.
    function automatic logic [PROD_W-1:0] csa_carry(
        input logic [PROD_W-1:0] x,
        input logic [PROD_W-1:0] y,
        input logic [PROD_W-1:0] z
    );
        logic [PROD_W-1:0] maj;
        maj = (x & y) | (x & z) | (y & z);
        return maj << 1;
    endfunction

    // One Baugh-Wooley row: sign-weighted bits are inverted so that every
    // term is positive; the matching -1 corrections fold into the constant
    // ones at columns 16 and 31.
    function automatic logic [WIDTH-1:0] bw_row(
        input logic [WIDTH-1:0] x,
        input logic             bit_i,
        input logic             last_row
    );
        logic [WIDTH-1:0] r;
        r = x & {WIDTH{bit_i}};
        if (last_row) begin
            r[WIDTH-2:0] = ~r[WIDTH-2:0];
        end else begin
            r[WIDTH-1] = ~r[WIDTH-1];
        end
        return r;
    endfunction

    logic [WIDTH-1:0]    pp_s   [WIDTH];
    logic [WIDTH-1:0]    pp1_r  [WIDTH];
    logic                p1_valid_r;

    logic [PROD_W-1:0]   l0_s   [16];
    logic [PROD_W-1:0]   l1_s   [11];
    logic [PROD_W-1:0]   l2_s   [8];
    logic [PROD_W-1:0]   l3_s   [6];
    logic [PROD_W-1:0]   l3q_s  [6];
    logic [PROD_W-1:0]   l4_s   [4];
    logic [PROD_W-1:0]   l5_s   [3];
    logic [PROD_W-1:0]   fin_a_s;
    logic [PROD_W-1:0]   fin_b_s;
    logic [LOW_BITS:0]   low_sum_s;

    logic                src_valid_s;
    logic                p1_adv_s;
    logic                p2_adv_s;

    logic [LOW_BITS-1:0]        low_prod_r;
    logic [PROD_W-LOW_BITS-1:0] row_a_r;
    logic [PROD_W-LOW_BITS-1:0] row_b_r;
    logic                       cin_r;
    logic                       p2_valid_r;

`ifdef WALLACE_MID_PIPE_EN
    logic [PROD_W-1:0]   pm_r   [6];
    logic                pm_valid_r;
    logic                pm_adv_s;
`endif

    // Handshake chain: a stage moves when empty or when its successor moves.
    always_comb begin
        p2_adv_s = !p2_valid_r || out_ready;
`ifdef WALLACE_MID_PIPE_EN
        pm_adv_s    = !pm_valid_r || p2_adv_s;
        p1_adv_s    = !p1_valid_r || pm_adv_s;
        src_valid_s = pm_valid_r;
`else
        p1_adv_s    = !p1_valid_r || p2_adv_s;
        src_valid_s = p1_valid_r;
`endif
        // The pipe is being emptied during reset, so it reports ready,
        // but the reset branch of the P1 register blocks any capture.
        if (rst) begin
            in_ready = 1'b1;
        end else begin
            in_ready = p1_adv_s;
        end
    end

    // Baugh-Wooley partial products from the live operands.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp_s[i] = bw_row(a, b[i], (i == WIDTH - 1));
        end
    end

    // P1 register: partial-product matrix captured on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            p1_valid_r <= 1'b0;
            pp1_r      <= '{default: {WIDTH{1'b0}}};
        end else if (p1_adv_s) begin
            p1_valid_r <= in_valid;
            if (in_valid) begin
                pp1_r <= pp_s;
            end
        end
    end

    // Align each row to its column weight and add the constant ones
    // (columns 16 and 31 are empty in row 0, so they can ride there).
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            l0_s[i] = {{WIDTH{1'b0}}, pp1_r[i]} << i;
        end
        l0_s[0][WIDTH]    = 1'b1;
        l0_s[0][PROD_W-1] = 1'b1;
    end

    // Reduction level 1: 16 rows -> 11 rows.
    always_comb begin
        for (int k = 0; k < 5; k++) begin
            l1_s[2*k]   = csa_sum  (l0_s[3*k], l0_s[3*k+1], l0_s[3*k+2]);
            l1_s[2*k+1] = csa_carry(l0_s[3*k], l0_s[3*k+1], l0_s[3*k+2]);
        end
        l1_s[10] = l0_s[15];
    end

    // Reduction level 2: 11 rows -> 8 rows.
    always_comb begin
        for (int k = 0; k < 3; k++) begin
            l2_s[2*k]   = csa_sum  (l1_s[3*k], l1_s[3*k+1], l1_s[3*k+2]);
            l2_s[2*k+1] = csa_carry(l1_s[3*k], l1_s[3*k+1], l1_s[3*k+2]);
        end
        l2_s[6] = l1_s[9];
        l2_s[7] = l1_s[10];
    end

    // Reduction level 3: 8 rows -> 6 rows.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            l3_s[2*k]   = csa_sum  (l2_s[3*k], l2_s[3*k+1], l2_s[3*k+2]);
            l3_s[2*k+1] = csa_carry(l2_s[3*k], l2_s[3*k+1], l2_s[3*k+2]);
        end
        l3_s[4] = l2_s[6];
        l3_s[5] = l2_s[7];
    end

`ifdef WALLACE_MID_PIPE_EN
    // P1b register: six-row intermediate sum between levels 3 and 4.
    always_ff @(posedge clk) begin
        if (rst) begin
            pm_valid_r <= 1'b0;
            pm_r       <= '{default: {PROD_W{1'b0}}};
        end else if (pm_adv_s) begin
            pm_valid_r <= p1_valid_r;
            if (p1_valid_r) begin
                pm_r <= l3_s;
            end
        end
    end

    // Later levels read the six rows from the P1b register.
    always_comb begin
        l3q_s = pm_r;
    end
`else
    // Later levels read the six rows straight from level 3.
    always_comb begin
        l3q_s = l3_s;
    end
`endif

    // Reduction level 4: 6 rows -> 4 rows.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            l4_s[2*k]   = csa_sum  (l3q_s[3*k], l3q_s[3*k+1], l3q_s[3*k+2]);
            l4_s[2*k+1] = csa_carry(l3q_s[3*k], l3q_s[3*k+1], l3q_s[3*k+2]);
        end
    end

    // Reduction levels 5 and 6: 4 rows -> 3 -> 2, then ripple the low byte.
    always_comb begin
        l5_s[0] = csa_sum  (l4_s[0], l4_s[1], l4_s[2]);
        l5_s[1] = csa_carry(l4_s[0], l4_s[1], l4_s[2]);
        l5_s[2] = l4_s[3];
        fin_a_s = csa_sum  (l5_s[0], l5_s[1], l5_s[2]);
        fin_b_s = csa_carry(l5_s[0], l5_s[1], l5_s[2]);
        low_sum_s = {1'b0, fin_a_s[LOW_BITS-1:0]} + {1'b0, fin_b_s[LOW_BITS-1:0]};
    end

    // P2 register: resolved low byte, two upper rows and the carry-in.
    always_ff @(posedge clk) begin
        if (rst) begin
            p2_valid_r <= 1'b0;
            low_prod_r <= {LOW_BITS{1'b0}};
            row_a_r    <= {(PROD_W-LOW_BITS){1'b0}};
            row_b_r    <= {(PROD_W-LOW_BITS){1'b0}};
            cin_r      <= 1'b0;
        end else if (p2_adv_s) begin
            p2_valid_r <= src_valid_s;
            if (src_valid_s) begin
                low_prod_r <= low_sum_s[LOW_BITS-1:0];
                cin_r      <= low_sum_s[LOW_BITS];
                row_a_r    <= fin_a_s[PROD_W-1:LOW_BITS];
                row_b_r    <= fin_b_s[PROD_W-1:LOW_BITS];
            end
        end
    end

    // Outputs come straight from the P2 registers.
    always_comb begin
        out_valid = p2_valid_r;
        low_prod  = low_prod_r;
        row_a     = row_a_r;
        row_b     = row_b_r;
        cin_out   = cin_r;
    end

endmodule

// File: tb/tb_wallace_reduce_16x16_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for wallace_reduce_16x16_pipe. A queue of operand pairs, each
// carrying its expected 32-bit product, feeds the DUT. A scoreboard queue
// records accepted operands in order and compares every output transfer
// against the reconstructed product {upper_sum, low_prod}. It also checks
// latency, output stability under backpressure, and reset behaviour.
// ---------------------------------------------------------------------------
module tb_wallace_reduce_16x16_pipe;

`ifdef WALLACE_MID_PIPE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  low_prod;
    logic [23:0] row_a;
    logic [23:0] row_b;
    logic        cin_out;

    wallace_reduce_16x16_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .low_prod  (low_prod),
        .row_a     (row_a),
        .row_b     (row_b),
        .cin_out   (cin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_pass;
    int          cyc;
    int          accepted;
    bit          chk_lat;
    bit          hold_pending;
    logic [56:0] hold_val;
    logic [63:0] stim_q [$];   // {a, b, expected product}
    logic [31:0] exp_q  [$];
    int          acc_q  [$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] make_op(input logic [15:0] x, input logic [15:0] y);
        logic signed [31:0] p;
        p = $signed(x) * $signed(y);
        return {x, y, p};
    endfunction

    // One clock: drive inputs, observe at negedge, advance past posedge.
    task automatic cycle(input bit ven, input bit rdy);
        logic [23:0] up;
        logic [31:0] e;
        int          l;
        bit          r_was;
        out_ready = rdy;
        if (ven && stim_q.size() > 0) begin
            in_valid = 1'b1;
            {a, b}   = stim_q[0][63:32];
        end else begin
            in_valid = 1'b0;
        end
        @(negedge clk);
        r_was = rst;
        up = row_a + row_b + {23'b0, cin_out};
        if (rst) begin
            check_val("in_ready_in_rst", {63'b0, in_ready}, 64'd1);
        end else begin
            if (hold_pending)
                check_val("hold_stable", {7'b0, row_a, row_b, cin_out, low_prod}, {7'b0, hold_val});
            if (out_valid && out_ready) begin
                check_val("scoreboard_nonempty", {63'b0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    l = acc_q.pop_front();
                    check_val("product", {32'b0, up, low_prod}, {32'b0, e});
                    if (chk_lat)
                        check_val("latency", 64'(cyc - l), 64'(LAT));
                    else if (cyc - l < LAT)
                        check_val("latency_min", 64'(cyc - l), 64'(LAT));
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(stim_q[0][31:0]);
                acc_q.push_back(cyc);
                void'(stim_q.pop_front());
                accepted++;
            end
        end
        hold_pending = (out_valid === 1'b1) && !out_ready && !rst;
        hold_val     = {row_a, row_b, cin_out, low_prod};
        @(posedge clk);
        #1;
        cyc++;
        if (r_was) begin
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic drain(input int budget, input bit rand_mode);
        int k;
        k = 0;
        while ((stim_q.size() != 0 || exp_q.size() != 0) && k < budget) begin
            if (rand_mode)
                cycle($urandom_range(0, 99) < 80, $urandom_range(0, 99) < 75);
            else
                cycle(1'b1, 1'b1);
            k++;
        end
        check_val("drain_done", {63'b0, (stim_q.size() == 0) && (exp_q.size() == 0)}, 64'd1);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_out_valid"}, {63'b0, out_valid}, 64'd0);
        check_val({tag, "_data"}, {7'b0, row_a, row_b, cin_out, low_prod}, 64'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        n_checks = 0; n_pass = 0; cyc = 0; accepted = 0;
        chk_lat = 1'b1; hold_pending = 1'b0; hold_val = '0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = 16'h0; b = 16'h0;

        // Reset with an operand offered: it must not be taken during reset.
        stim_q.push_back({16'd3, 16'd5, 32'h0000000F});
        repeat (3) cycle(1'b1, 1'b1);
        rst = 1'b0;
        check_zero_outputs("reset");

        // Directed products with known values, no backpressure.
        stim_q.push_back({16'hFFFF, 16'h0001, 32'hFFFFFFFF});
        stim_q.push_back({16'h8000, 16'h8000, 32'h40000000});
        stim_q.push_back({16'h7FFF, 16'h8000, 32'hC0008000});
        stim_q.push_back({16'h0000, 16'h1234, 32'h00000000});
        drain(50, 1'b0);

        // Backpressure: four back-to-back pairs, downstream stalled 5 cycles.
        chk_lat = 1'b0;
        accepted = 0;
        for (int i = 0; i < 4; i++) stim_q.push_back(make_op(16'($urandom), 16'($urandom)));
        repeat (5) cycle(1'b1, 1'b0);
        check_val("bp_accepts", 64'(accepted), 64'(LAT));
        check_val("bp_in_ready", {63'b0, in_ready}, 64'd0);
        check_val("bp_out_valid", {63'b0, out_valid}, 64'd1);
        drain(50, 1'b0);

        // Reset with the pipe full, then a fresh operation.
        for (int i = 0; i < 4; i++) stim_q.push_back(make_op(16'($urandom), 16'($urandom)));
        repeat (4) cycle(1'b1, 1'b0);
        stim_q.delete();
        rst = 1'b1;
        cycle(1'b0, 1'b0);
        rst = 1'b0;
        check_zero_outputs("mid_reset");
        chk_lat = 1'b1;
        stim_q.push_back({16'hFFF9, 16'd9, 32'hFFFFFFC1});
        drain(20, 1'b0);

        // Randomised pairs with random valid gaps and random backpressure.
        chk_lat = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 15) == 0) ra = 16'h8000;
            if ($urandom_range(0, 15) == 0) rb = 16'h7FFF;
            if ($urandom_range(0, 15) == 0) ra = 16'hFFFF;
            stim_q.push_back(make_op(ra, rb));
        end
        drain(60000, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
